// File: rtl/pipeline_exe_muldiv.sv
// EXE stage: RV32I ALU plus RV32M mul/div/rem feeding the EXE->MEM pipeline register.
// Define MUL_SINGLE_CYCLE_EN for a combinational multiplier; div/rem stays iterative.
`ifndef DMEM_NO
`define DMEM_NO 4'h0
`endif

module pipeline_exe_muldiv #(
   parameter int unsigned XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h80000000
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush_i,
   input  logic [4:0]      alu_op_d_i,
   input  logic [XLEN-1:0] src_a_d_i,
   input  logic [XLEN-1:0] src_b_d_i,
   input  logic [XLEN-1:0] store_data_d_i,
   input  logic [3:0]      dmem_type_d_i,
   input  logic [XLEN-1:0] extended_imm_d_i,
   input  logic [XLEN-1:0] pc_plus_d_i,
   input  logic            reg_write_en_d_i,
   input  logic [4:0]      rd_idx_d_i,
   input  logic [3:0]      result_src_d_i,
   input  logic [XLEN-1:0] pc_instr_d_i,
   output logic            stall_e_o,
   output logic [XLEN-1:0] alu_result_e_o,
   output logic [XLEN-1:0] rs1_e_o,
   output logic [3:0]      dmem_type_e_o,
   output logic [XLEN-1:0] extended_imm_e_o,
   output logic [XLEN-1:0] pc_plus_e_o,
   output logic            reg_write_en_e_o,
   output logic [4:0]      rd_idx_e_o,
   output logic [3:0]      result_src_e_o,
   output logic [XLEN-1:0] pc_instr_e_o
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  count_q, op_q;
   logic [31:0] hi_q, lo_q, opnd_q;
   logic        neg_q, neg_r_q;

   logic        is_mul_op, is_div_op, is_multi, a_sgn, b_sgn, a_neg, b_neg;
   logic        div_ovf, div_special, start;
   logic [31:0] mag_a, mag_b, step_hi, step_lo, alu_res, md_result;
   logic [32:0] mul_sum;
   logic [33:0] div_diff;
   logic [63:0] prod_c;

   always_comb begin
      is_mul_op = (alu_op_d_i >= 5'd10) && (alu_op_d_i <= 5'd13);
      is_div_op = (alu_op_d_i >= 5'd14) && (alu_op_d_i <= 5'd17);
`ifdef MUL_SINGLE_CYCLE_EN
      is_multi  = is_div_op;
`else
      is_multi  = is_mul_op || is_div_op;
`endif
      a_sgn = (alu_op_d_i == 5'd11) || (alu_op_d_i == 5'd12) ||
              (alu_op_d_i == 5'd14) || (alu_op_d_i == 5'd16);
      b_sgn = (alu_op_d_i == 5'd11) || (alu_op_d_i == 5'd14) || (alu_op_d_i == 5'd16);
      a_neg = a_sgn && src_a_d_i[31];
      b_neg = b_sgn && src_b_d_i[31];
      mag_a = a_neg ? 32'd0 - src_a_d_i : src_a_d_i;
      mag_b = b_neg ? 32'd0 - src_b_d_i : src_b_d_i;
      div_ovf = ((alu_op_d_i == 5'd14) || (alu_op_d_i == 5'd16)) &&
                (src_a_d_i == 32'h80000000) && (src_b_d_i == 32'hffffffff);
      div_special = is_div_op && ((src_b_d_i == 32'd0) || div_ovf);
      start = (state_q == StIdle) && is_multi && !flush_i;
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (is_multi) state_d = div_special ? StDone : StBusy;
         StBusy:  if (count_q == 5'd31) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (flush_i) state_d = StIdle;
   end

   // FSM: outputs
   always_comb begin
      stall_e_o = resetn && !flush_i &&
                  (((state_q == StIdle) && is_multi) || (state_q == StBusy));
   end

   // One iteration: shift-add multiply or restoring divide on {hi_q, lo_q}
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
      div_diff = {1'b0, hi_q, lo_q[31]} - {2'b00, opnd_q};
      if (op_q <= 5'd13) begin
         step_hi = mul_sum[32:1];
         step_lo = {mul_sum[0], lo_q[31:1]};
      end else if (!div_diff[33]) begin
         step_hi = div_diff[31:0];
         step_lo = {lo_q[30:0], 1'b1};
      end else begin
         step_hi = {hi_q[30:0], lo_q[31]};
         step_lo = {lo_q[30:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         op_q    <= alu_op_d_i;
         count_q <= 5'd0;
         if (div_special) begin
            // Final values stored directly; sign correction disabled
            lo_q    <= div_ovf ? 32'h80000000 : 32'hffffffff;
            hi_q    <= div_ovf ? 32'd0 : src_a_d_i;
            opnd_q  <= 32'd0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
         end else begin
            hi_q    <= 32'd0;
            lo_q    <= is_div_op ? mag_a : mag_b;
            opnd_q  <= is_div_op ? mag_b : mag_a;
            neg_q   <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
         end
      end else if (state_q == StBusy) begin
         count_q <= count_q + 5'd1;
         hi_q    <= step_hi;
         lo_q    <= step_lo;
      end
   end

   always_comb begin
      prod_c = neg_q ? 64'd0 - {hi_q, lo_q} : {hi_q, lo_q};
      case (op_q)
         5'd10:               md_result = prod_c[31:0];
         5'd11, 5'd12, 5'd13: md_result = prod_c[63:32];
         5'd14, 5'd15:        md_result = neg_q ? 32'd0 - lo_q : lo_q;
         default:             md_result = neg_r_q ? 32'd0 - hi_q : hi_q;
      endcase
   end

`ifdef MUL_SINGLE_CYCLE_EN
   logic signed [32:0] mul_a, mul_b;
   logic signed [65:0] mul_p;
   always_comb begin
      mul_a = {a_sgn && src_a_d_i[31], src_a_d_i};
      mul_b = {b_sgn && src_b_d_i[31], src_b_d_i};
      mul_p = mul_a * mul_b;
   end
`endif

   always_comb begin
      unique case (alu_op_d_i)
         5'd0:    alu_res = src_a_d_i + src_b_d_i;
         5'd1:    alu_res = src_a_d_i - src_b_d_i;
         5'd2:    alu_res = src_a_d_i << src_b_d_i[4:0];
         5'd3:    alu_res = {31'd0, $signed(src_a_d_i) < $signed(src_b_d_i)};
         5'd4:    alu_res = {31'd0, src_a_d_i < src_b_d_i};
         5'd5:    alu_res = src_a_d_i ^ src_b_d_i;
         5'd6:    alu_res = src_a_d_i >> src_b_d_i[4:0];
         5'd7:    alu_res = $unsigned($signed(src_a_d_i) >>> src_b_d_i[4:0]);
         5'd8:    alu_res = src_a_d_i | src_b_d_i;
         5'd9:    alu_res = src_a_d_i & src_b_d_i;
`ifdef MUL_SINGLE_CYCLE_EN
         5'd10:   alu_res = mul_p[31:0];
         5'd11, 5'd12, 5'd13: alu_res = mul_p[63:32];
`endif
         default: alu_res = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         alu_result_e_o   <= '0;
         rs1_e_o          <= '0;
         dmem_type_e_o    <= `DMEM_NO;
         extended_imm_e_o <= '0;
         pc_plus_e_o      <= '0;
         reg_write_en_e_o <= 1'b0;
         rd_idx_e_o       <= 5'd0;
         result_src_e_o   <= 4'd0;
         pc_instr_e_o     <= RESET_PC;
      end else if (flush_i || stall_e_o) begin
         // Bubble: kill the write-side fields, leave the rest holding
         alu_result_e_o   <= '0;
         dmem_type_e_o    <= `DMEM_NO;
         reg_write_en_e_o <= 1'b0;
         rd_idx_e_o       <= 5'd0;
         result_src_e_o   <= 4'd0;
      end else begin
         alu_result_e_o   <= (state_q == StDone) ? md_result : alu_res;
         rs1_e_o          <= store_data_d_i;
         dmem_type_e_o    <= dmem_type_d_i;
         extended_imm_e_o <= extended_imm_d_i;
         pc_plus_e_o      <= pc_plus_d_i;
         reg_write_en_e_o <= reg_write_en_d_i;
         rd_idx_e_o       <= rd_idx_d_i;
         result_src_e_o   <= result_src_d_i;
         pc_instr_e_o     <= pc_instr_d_i;
      end
   end

endmodule

// File: tb/tb_pipeline_exe_muldiv.sv
// Self-checking bench for pipeline_exe_muldiv: directed ops, scoreboard of expected writes,
// stall-length checks, flush and mid-operation reset.
`ifndef DMEM_NO
`define DMEM_NO 4'h0
`endif

module tb_pipeline_exe_muldiv;

`ifdef MUL_SINGLE_CYCLE_EN
   localparam int MulStall = 0;
`else
   localparam int MulStall = 33;
`endif

   logic        clk = 1'b0;
   logic        resetn, flush_i, reg_write_en_d_i;
   logic [4:0]  alu_op_d_i, rd_idx_d_i;
   logic [31:0] src_a_d_i, src_b_d_i, store_data_d_i, extended_imm_d_i, pc_plus_d_i;
   logic [31:0] pc_instr_d_i;
   logic [3:0]  dmem_type_d_i, result_src_d_i;
   logic        stall_e_o, reg_write_en_e_o;
   logic [31:0] alu_result_e_o, rs1_e_o, extended_imm_e_o, pc_plus_e_o, pc_instr_e_o;
   logic [3:0]  dmem_type_e_o, result_src_e_o;
   logic [4:0]  rd_idx_e_o;

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [4:0] rd_next = 5'd1;

   initial forever #5 clk = ~clk;

   pipeline_exe_muldiv dut (
      .clk              (clk),
      .resetn           (resetn),
      .flush_i          (flush_i),
      .alu_op_d_i       (alu_op_d_i),
      .src_a_d_i        (src_a_d_i),
      .src_b_d_i        (src_b_d_i),
      .store_data_d_i   (store_data_d_i),
      .dmem_type_d_i    (dmem_type_d_i),
      .extended_imm_d_i (extended_imm_d_i),
      .pc_plus_d_i      (pc_plus_d_i),
      .reg_write_en_d_i (reg_write_en_d_i),
      .rd_idx_d_i       (rd_idx_d_i),
      .result_src_d_i   (result_src_d_i),
      .pc_instr_d_i     (pc_instr_d_i),
      .stall_e_o        (stall_e_o),
      .alu_result_e_o   (alu_result_e_o),
      .rs1_e_o          (rs1_e_o),
      .dmem_type_e_o    (dmem_type_e_o),
      .extended_imm_e_o (extended_imm_e_o),
      .pc_plus_e_o      (pc_plus_e_o),
      .reg_write_en_e_o (reg_write_en_e_o),
      .rd_idx_e_o       (rd_idx_e_o),
      .result_src_e_o   (result_src_e_o),
      .pc_instr_e_o     (pc_instr_e_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nop();
      alu_op_d_i       = 5'd0;
      reg_write_en_d_i = 1'b0;
      rd_idx_d_i       = 5'd0;
      result_src_d_i   = 4'd0;
      dmem_type_d_i    = `DMEM_NO;
   endtask

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_op_d_i       = op;
      src_a_d_i        = a;
      src_b_d_i        = b;
      store_data_d_i   = a ^ 32'h5a5a0000;
      reg_write_en_d_i = 1'b1;
      rd_idx_d_i       = rd_next;
      result_src_d_i   = 4'b0001;
      dmem_type_d_i    = 4'h2;
      pc_instr_d_i     = pc_instr_d_i + 32'd4;
      rd_next          = (rd_next == 5'd31) ? 5'd1 : rd_next + 5'd1;
   endtask

   // Present one op, hold it while stalled, and expect exactly one write from it
   task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
      int n;
      @(negedge clk);
      sb_q.push_back('{tag, exp, rd_next});
      drive(op, a, b);
      #1;
      n = 0;
      while (stall_e_o === 1'b1 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_stall"}, 32'(n), 32'(exp_stall));
      @(posedge clk);
      #1;
      check({tag, "_pc"}, pc_instr_e_o, pc_instr_d_i);
      check({tag, "_rs1"}, rs1_e_o, store_data_d_i);
      #1;
      nop();
   endtask

   // Scoreboard: every write that reaches MEM must match the oldest outstanding op
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (resetn === 1'b1 && reg_write_en_e_o === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("spurious_write", 32'(reg_write_en_e_o), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check({e.tag, "_result"}, alu_result_e_o, e.res);
               check({e.tag, "_rd"}, 32'(rd_idx_e_o), 32'(e.rd));
            end
         end
      end
   end

   initial begin
      resetn           = 1'b0;
      flush_i          = 1'b0;
      src_a_d_i        = 32'h0;
      src_b_d_i        = 32'h0;
      store_data_d_i   = 32'h1111;
      extended_imm_d_i = 32'habcd;
      pc_plus_d_i      = 32'h2004;
      pc_instr_d_i     = 32'h1000;
      nop();
      alu_op_d_i       = 5'd14;
      reg_write_en_d_i = 1'b1;
      rd_idx_d_i       = 5'd3;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", 32'(stall_e_o), 32'd0);
      check("rst_alu_result", alu_result_e_o, 32'h0);
      check("rst_rs1", rs1_e_o, 32'h0);
      check("rst_dmem_type", 32'(dmem_type_e_o), 32'(`DMEM_NO));
      check("rst_reg_write", 32'(reg_write_en_e_o), 32'd0);
      check("rst_rd_idx", 32'(rd_idx_e_o), 32'd0);
      check("rst_pc_instr", pc_instr_e_o, 32'h80000000);
      nop();
      @(negedge clk);
      resetn = 1'b1;

      issue("add",     5'd0,  32'h7fffffff, 32'h1,        32'h80000000, 0);
      issue("sub",     5'd1,  32'h0,        32'h1,        32'hffffffff, 0);
      issue("sra",     5'd7,  32'h80000000, 32'h4,        32'hf8000000, 0);
      issue("slt",     5'd3,  32'hffffffff, 32'h1,        32'h1,        0);
      issue("sltu",    5'd4,  32'hffffffff, 32'h1,        32'h0,        0);
      issue("op20",    5'd20, 32'h12345678, 32'h1,        32'h0,        0);
      issue("div",     5'd14, 32'hfffffff9, 32'h2,        32'hfffffffd, 33);
      issue("rem",     5'd16, 32'hfffffff9, 32'h2,        32'hffffffff, 33);
      issue("divu",    5'd15, 32'd100,      32'd7,        32'd14,       33);
      issue("divu0",   5'd15, 32'h5,        32'h0,        32'hffffffff, 1);
      issue("remu0",   5'd17, 32'h5,        32'h0,        32'h5,        1);
      issue("div_ovf", 5'd14, 32'h80000000, 32'hffffffff, 32'h80000000, 1);
      issue("rem_ovf", 5'd16, 32'h80000000, 32'hffffffff, 32'h0,        1);
      issue("mul",     5'd10, 32'h12345678, 32'h10,       32'h23456780, MulStall);
      issue("mulh",    5'd11, 32'hffffffff, 32'hffffffff, 32'h0,        MulStall);
      issue("mulhu",   5'd13, 32'hffffffff, 32'hffffffff, 32'hfffffffe, MulStall);
      issue("mulhsu",  5'd12, 32'hffffffff, 32'h2,        32'hffffffff, MulStall);

      // Flush while the divider is at iteration 10
      @(negedge clk);
      drive(5'd14, 32'd100, 32'd7);
      repeat (11) @(posedge clk);
      @(negedge clk);
      #1;
      check("busy_before_flush", 32'(stall_e_o), 32'd1);
      flush_i = 1'b1;
      #1;
      check("flush_stall", 32'(stall_e_o), 32'd0);
      @(posedge clk);
      #1;
      check("flush_reg_write", 32'(reg_write_en_e_o), 32'd0);
      check("flush_rd_idx", 32'(rd_idx_e_o), 32'd0);
      check("flush_alu_result", alu_result_e_o, 32'h0);
      flush_i = 1'b0;
      nop();
      issue("add_after_flush", 5'd0, 32'd2, 32'd3, 32'd5, 0);

      // Reset in the middle of a divide
      @(negedge clk);
      drive(5'd14, 32'hfffffff9, 32'h2);
      repeat (5) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("midrst_stall", 32'(stall_e_o), 32'd0);
      @(posedge clk);
      #1;
      check("midrst_alu_result", alu_result_e_o, 32'h0);
      check("midrst_reg_write", 32'(reg_write_en_e_o), 32'd0);
      check("midrst_dmem_type", 32'(dmem_type_e_o), 32'(`DMEM_NO));
      check("midrst_pc_instr", pc_instr_e_o, 32'h80000000);
      nop();
      @(negedge clk);
      resetn = 1'b1;
      issue("add_after_rst", 5'd0, 32'h10, 32'h20, 32'h30, 0);

      repeat (3) @(posedge clk);
      #2;
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
